voice_mixer: RTL and testbench

Sample-rate mixing stage between the eight Voice outputs and the biquad filter input. It replaces the wrapping 16-bit voice sum with a time-multiplexed accumulate, a master gain and a step-gain peak limiter, and saturates the result to 16 bits. It produces one mixed sample per frame strobe and runs on the system clock.

---
 rtl/voice_mixer.sv | 150 +++++++++++++++
 tb/tb_voice_mixer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// Frame-rate voice mixer: time-multiplexed accumulate of eight voices, master gain,
// step-gain peak limiter and 16-bit saturation. One mixed sample per sample_strobe.
module voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int W          = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_strobe,
    input  logic [NUM_VOICES*W-1:0] voice_in,
    input  logic [15:0]             master_gain,
    input  logic                    lim_en,
    input  logic [15:0]             lim_threshold,
    input  logic [15:0]             lim_attack,
    input  logic [15:0]             lim_release,
    output logic [W-1:0]            mix_out,
    output logic                    mix_valid,
    output logic                    clip,
    output logic                    overrun,
    output logic [15:0]             lim_gain
);
    localparam int AW = W + 3;
    localparam int YW = W + 4;
    localparam int IW = $clog2(NUM_VOICES);
    localparam int GW = AW + 17;
    localparam int LW = YW + 17;

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_GAIN, S_LIMIT, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic [NUM_VOICES*W-1:0] voices_q, voices_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic signed [YW-1:0]    y_q, y_d;
    logic [W-1:0]            mix_out_q, mix_out_d;
    logic                    mix_valid_q, mix_valid_d;
    logic                    clip_q, clip_d;
    logic                    overrun_q, overrun_d;
    logic [15:0]             lim_gain_q, lim_gain_d;

    logic signed [W-1:0]     voice_sel;
    logic signed [GW-1:0]    gain_prod;
    logic signed [LW-1:0]    lim_prod;
    logic signed [YW-1:0]    z;
    logic [YW-1:0]           z_mag;
    logic [16:0]             rel_sum;
    logic                    sat_hi, sat_lo;

    always_comb begin
        state_d     = state_q;
        voices_d    = voices_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        y_d         = y_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        clip_d      = clip_q;
        overrun_d   = overrun_q;
        lim_gain_d  = lim_gain_q;

        voice_sel = voices_q[W*int'(idx_q) +: W];
        gain_prod = GW'(acc_q) * GW'($signed({1'b0, master_gain}));
        lim_prod  = LW'(y_q) * LW'($signed({1'b0, lim_gain_q}));
        // The limiter scales with the gain held from the previous frame.
        z         = lim_en ? YW'(lim_prod >>> 15) : y_q;
        z_mag     = z[YW-1] ? YW'(-z) : YW'(z);
        rel_sum   = {1'b0, lim_gain_q} + {1'b0, lim_release};
        sat_hi    = ~z[YW-1] & (|z[YW-2:W-1]);
        sat_lo    = z[YW-1] & ~(&z[YW-2:W-1]);

        if (sample_strobe && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (sample_strobe) begin
                    voices_d = voice_in;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + AW'(voice_sel);
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(NUM_VOICES - 1)) begin
                    state_d = S_GAIN;
                end
            end
            S_GAIN: begin
                y_d     = YW'(gain_prod >>> 15);
                state_d = S_LIMIT;
            end
            S_LIMIT: begin
                if (!lim_en) begin
                    lim_gain_d = 16'h8000;
                end else if (z_mag > {{(YW-16){1'b0}}, lim_threshold}) begin
                    lim_gain_d = (lim_gain_q > lim_attack) ? lim_gain_q - lim_attack : 16'd0;
                end else begin
                    lim_gain_d = (rel_sum > 17'h08000) ? 16'h8000 : rel_sum[15:0];
                end
                mix_out_d   = sat_hi ? {1'b0, {(W-1){1'b1}}} :
                              sat_lo ? {1'b1, {(W-1){1'b0}}} : z[W-1:0];
                clip_d      = sat_hi | sat_lo;
                mix_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            voices_q    <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            y_q         <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            overrun_q   <= 1'b0;
            lim_gain_q  <= 16'h8000;
        end else begin
            state_q     <= state_d;
            voices_q    <= voices_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            y_q         <= y_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            clip_q      <= clip_d;
            overrun_q   <= overrun_d;
            lim_gain_q  <= lim_gain_d;
        end
    end

    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign clip      = clip_q;
    assign overrun   = overrun_q;
    assign lim_gain  = lim_gain_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: directed frames with known results, random unity-limiter
// frames against a small arithmetic model, overrun and mid-frame reset.
module tb_voice_mixer;
    localparam int W  = 16;
    localparam int NV = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_strobe = 1'b0;
    logic [NV*W-1:0] voice_in = '0;
    logic [15:0]   master_gain = 16'h8000;
    logic          lim_en = 1'b0;
    logic [15:0]   lim_threshold = 16'h4000;
    logic [15:0]   lim_attack = 16'h1000;
    logic [15:0]   lim_release = 16'h0010;
    logic [W-1:0]  mix_out;
    logic          mix_valid;
    logic          clip;
    logic          overrun;
    logic [15:0]   lim_gain;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [2*W:0] exp_q[$];   // {mix_out, clip, lim_gain}
    int           t_q[$];     // cycle in which the strobe was driven

    voice_mixer #(.NUM_VOICES(NV), .W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .voice_in      (voice_in),
        .master_gain   (master_gain),
        .lim_en        (lim_en),
        .lim_threshold (lim_threshold),
        .lim_attack    (lim_attack),
        .lim_release   (lim_release),
        .mix_out       (mix_out),
        .mix_valid     (mix_valid),
        .clip          (clip),
        .overrun       (overrun),
        .lim_gain      (lim_gain)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every mix_valid pops one expected sample.
    always @(negedge clk) begin
        logic [2*W:0] e;
        int           t;
        if (mix_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 32'(mix_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                t = t_q.pop_front();
                check_eq("mix_out", 32'(mix_out), 32'(e[2*W:W+1]));
                check_eq("clip", 32'(clip), 32'(e[W]));
                check_eq("lim_gain", 32'(lim_gain), 32'(e[W-1:0]));
                check_eq("latency", cyc - t, 32'd11);
            end
        end
    end

    function automatic logic [NV*W-1:0] fill(input logic [W-1:0] v);
        return {NV{v}};
    endfunction

    function automatic logic [2*W:0] model_mix(input logic [NV*W-1:0] v, input logic [15:0] g);
        longint acc;
        longint y;
        logic [W-1:0] m;
        logic c;
        acc = 0;
        for (int i = 0; i < NV; i++) acc += longint'($signed(v[i*W +: W]));
        y = (acc * longint'(g)) >>> 15;
        if (y > 32767) begin
            m = 16'h7FFF; c = 1'b1;
        end else if (y < -32768) begin
            m = 16'h8000; c = 1'b1;
        end else begin
            m = y[W-1:0]; c = 1'b0;
        end
        return {m, c, 16'h8000};
    endfunction

    task automatic strobe_frame(input logic [NV*W-1:0] v, input logic [W-1:0] exp_mix,
                                input logic exp_clip, input logic [15:0] exp_gain);
        @(negedge clk);
        voice_in = v;
        sample_strobe = 1'b1;
        exp_q.push_back({exp_mix, exp_clip, exp_gain});
        t_q.push_back(cyc);
        @(negedge clk);
        sample_strobe = 1'b0;
    endtask

    task automatic run_frame(input logic [NV*W-1:0] v, input logic [W-1:0] exp_mix,
                             input logic exp_clip, input logic [15:0] exp_gain);
        strobe_frame(v, exp_mix, exp_clip, exp_gain);
        repeat (12) @(negedge clk);
        check_eq("frame_done", exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_mix_out"}, 32'(mix_out), 32'd0);
        check_eq({tag, "_mix_valid"}, 32'(mix_valid), 32'd0);
        check_eq({tag, "_clip"}, 32'(clip), 32'd0);
        check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
        check_eq({tag, "_lim_gain"}, 32'(lim_gain), 32'h8000);
    endtask

    initial begin
        logic [NV*W-1:0] rv;
        logic [2*W:0]    e;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("rst");

        run_frame(fill(16'h0100), 16'h0800, 1'b0, 16'h8000);
        run_frame(fill(16'h1000), 16'h7FFF, 1'b1, 16'h8000);
        run_frame(fill(16'h8000), 16'h8000, 1'b1, 16'h8000);
        run_frame(fill(16'h0000), 16'h0000, 1'b0, 16'h8000);

        master_gain = 16'h4000;
        run_frame(fill(16'h0200), 16'h0800, 1'b0, 16'h8000);
        run_frame({{(NV-1)*W{1'b0}}, 16'hFFFD}, 16'hFFFE, 1'b0, 16'h8000);

        master_gain = 16'h8000;
        lim_en = 1'b1;
        run_frame(fill(16'h0C00), 16'h6000, 1'b0, 16'h7000);
        run_frame(fill(16'h0C00), 16'h5400, 1'b0, 16'h6000);
        run_frame(fill(16'h0C00), 16'h4800, 1'b0, 16'h5000);
        run_frame(fill(16'h0C00), 16'h3C00, 1'b0, 16'h5010);
        lim_en = 1'b0;
        run_frame(fill(16'h0C00), 16'h6000, 1'b0, 16'h8000);
        check_eq("overrun_clear", 32'(overrun), 32'd0);

        // Second strobe three cycles into the frame must be dropped.
        strobe_frame(fill(16'h0100), 16'h0800, 1'b0, 16'h8000);
        repeat (2) @(negedge clk);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("overrun_frame_done", exp_q.size(), 32'd0);
        check_eq("overrun_set", 32'(overrun), 32'd1);

        for (int i = 0; i < 6; i++) begin
            rv = {$urandom, $urandom, $urandom, $urandom};
            if (i % 2 == 1) rv = rv >> 2;
            master_gain = 16'($urandom_range(0, 16'hFFFF));
            e = model_mix(rv, master_gain);
            run_frame(rv, e[2*W:W+1], e[W], e[W-1:0]);
        end
        check_eq("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the fifth ACCUM cycle aborts the frame.
        master_gain = 16'h8000;
        lim_en = 1'b1;
        run_frame(fill(16'h0C00), 16'h6000, 1'b0, 16'h7000);
        @(negedge clk);
        voice_in = fill(16'h1000);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("midrst");
        repeat (14) @(negedge clk);
        check_eq("midrst_no_valid", exp_q.size(), 32'd0);
        run_frame(fill(16'h0100), 16'h0800, 1'b0, 16'h8000);

        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
